// File: rtl/fb_scanout_arbiter_if.sv
// Frame-buffer arbiter bus: scanout timing, writer handshake, RAM port, pixel output.
// The master modport is the arbiter's view; the slave modport is its environment.
interface fb_scanout_arbiter_if;
  logic        pix_en;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        video_on;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;
  logic [15:0] stall_cnt;

  modport master (
    input  pix_en, h_count, v_count, video_on, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_en, mem_we, mem_addr, mem_wdata, rgb, stall_cnt
  );

  modport slave (
    output pix_en, h_count, v_count, video_on, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_en, mem_we, mem_addr, mem_wdata, rgb, stall_cnt
  );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Single-port 256x240 frame-buffer arbiter: 2x-scaled scanout reads pre-empt writer requests.
// Optional writer stall counter is built when FB_STALL_CNT_EN is defined.
module fb_scanout_arbiter #(
  parameter int unsigned H_OFFSET   = 64,
  parameter logic [11:0] BORDER_RGB = 12'h000,
  parameter int unsigned FB_DEPTH   = 61440
) (
  input logic                  clk,
  input logic                  rst,
  fb_scanout_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

  state_t      state_q, state_d;
  logic [9:0]  h_rel;
  logic        win;
  logic        need_fetch;
  logic        wr_in_range;
  logic [15:0] rd_addr;
  logic        unused_ok;

  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        wr_ack_q, wr_ack_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [11:0] mem_wdata_q, mem_wdata_d;
  logic [11:0] pix_buf_q;
  logic [11:0] rgb_q;
  logic        disp_q;
  logic        win_q;

  assign h_rel       = bus.h_count - 10'(H_OFFSET);
  assign win         = (32'(bus.h_count) >= H_OFFSET) && (32'(bus.h_count) < H_OFFSET + 32'd512);
  assign need_fetch  = bus.pix_en & bus.video_on & win & ~h_rel[0];
  assign rd_addr     = {bus.v_count[8:1], h_rel[8:1]};
  assign wr_in_range = 32'(bus.wr_addr) < FB_DEPTH;
  assign unused_ok   = ^{bus.v_count[9], bus.v_count[0], h_rel[9]};

  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (need_fetch) state_d = S_RD;
        else if (bus.wr_req && !wr_ack_q) state_d = S_WR;
      end
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_IDLE;
      S_WR:    state_d = need_fetch ? S_RD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // RAM controls are registered, so they are derived from the state being entered
    if (state_d == S_RD) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end else if (state_d == S_WR) begin
      mem_en_d    = wr_in_range;
      mem_we_d    = wr_in_range;
      mem_addr_d  = bus.wr_addr;
      mem_wdata_d = bus.wr_data;
      wr_ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pix_buf_q   <= '0;
      rgb_q       <= '0;
      disp_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      wr_ack_q    <= wr_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == S_CAP) pix_buf_q <= bus.mem_rdata;
      // rgb shows the previous pixel, so display flags are delayed by one strobe
      if (bus.pix_en) begin
        rgb_q  <= disp_q ? (win_q ? pix_buf_q : BORDER_RGB) : '0;
        disp_q <= bus.video_on;
        win_q  <= win;
      end
    end
  end

  assign bus.wr_ack    = wr_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rgb       = rgb_q;

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.pix_en && bus.h_count == '0 && bus.v_count == '0) begin
      stall_q <= '0;
    end else if (bus.wr_req && !wr_ack_q && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
